// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared keypad/LED-matrix geometry, key code mapping and scanner FSM encoding.
// Also used by the LED scan driver, so the matrix dimensions stay in one place.
package kp_pkg;

  localparam int KP_ROWS   = 5;
  localparam int KP_COLS   = 7;
  localparam int KP_CODE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_EMIT
  } kp_state_e;

  function automatic int unsigned KEY_CODE(input int unsigned r, input int unsigned c,
                                           input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key event channel: valid/ready handshake carrying a key code and press/release flag.
// The master holds valid, code and press stable until the slave accepts them.
interface keypad_matrix_scanner_if
  import kp_pkg::*;
#(
  parameter int CODE_W = KP_CODE_W
);
  logic              key_valid;
  logic              key_ready;
  logic [CODE_W-1:0] key_code;
  logic              key_press;

  modport master (output key_valid, output key_code, output key_press, input key_ready);
  modport slave  (input key_valid, input key_code, input key_press, output key_ready);
endinterface

// File: rtl/keypad_matrix_scanner_debounce.sv
// One key's debounced state: a stable bit and a saturating change counter.
// Updates only on its row's sample strobe; clear flips the state once the change is reported.
module kp_debounce_cell #(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic raw,
  input  logic clear,
  output logic stable,
  output logic pending
);
  logic       stable_q, stable_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (clear) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else if (sample) begin
      if (raw == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q != 2'(DEBOUNCE_SCANS)) begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable  = stable_q;
  assign pending = (cnt_q == 2'(DEBOUNCE_SCANS));
endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-scanned key matrix with per-key debounce; emits press/release key codes on a valid/ready channel.
// Row dwell SCAN_DIV clocks + 1 sample + COLS emit cycles; a busy output slot stalls the emit walk on that column.
module keypad_matrix_scanner
  import kp_pkg::*;
#(
  parameter int ROWS           = KP_ROWS,
  parameter int COLS           = KP_COLS,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int CODE_W         = KP_CODE_W
) (
  input  logic            CLOCK_50,
  input  logic            rst_n,
  input  logic            en,
  input  logic [COLS-1:0] col_n,
  output logic [ROWS-1:0] row_n,
  output logic            overrun,
  keypad_matrix_scanner_if.master key_if
);
  localparam int NK  = ROWS * COLS;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW  = (NK > 1) ? $clog2(NK) : 1;
  localparam int DWW = $clog2(SCAN_DIV);

  kp_state_e         state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic [DWW-1:0]    dwell_q, dwell_d;
  logic [ROWS-1:0]   row_n_q, row_n_d;
  logic              key_valid_q, key_valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_press_q, key_press_d;
  logic              overrun_q, overrun_d;
  logic [COLS-1:0]   col_s1_q, col_s2_q;

  logic [COLS-1:0]   raw;
  logic [NK-1:0]     stable, pending, clr_vec, sat_hit;
  logic [IW-1:0]     cur_idx;
  logic              slot_free, flip;

  assign raw = ~col_s2_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int K = r * COLS + c;
      logic samp;
      assign samp       = (state_q == ST_SAMPLE) && (row_q == RW'(r));
      assign clr_vec[K] = flip && (cur_idx == IW'(K));
      // A saturated counter seeing yet another differing sample would lose a change.
      assign sat_hit[K] = samp && pending[K] && (raw[c] != stable[K]);

      kp_debounce_cell #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_cell (
        .clk     (CLOCK_50),
        .rst_n   (rst_n),
        .sample  (samp),
        .raw     (raw[c]),
        .clear   (clr_vec[K]),
        .stable  (stable[K]),
        .pending (pending[K])
      );
    end
  end

  always_comb begin
    slot_free   = !key_valid_q || key_if.key_ready;
    cur_idx     = IW'(KEY_CODE(32'(row_q), 32'(col_q), COLS));
    flip        = (state_q == ST_EMIT) && pending[cur_idx] && slot_free;
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    dwell_d     = dwell_q;
    key_valid_d = key_valid_q && !key_if.key_ready;
    key_code_d  = key_code_q;
    key_press_d = key_press_q;
    overrun_d   = overrun_q | (|sat_hit);

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_DRIVE;
          row_d   = '0;
          dwell_d = '0;
        end
      end
      ST_DRIVE: begin
        if (dwell_q == DWW'(SCAN_DIV - 1)) begin
          dwell_d = '0;
          state_d = en ? ST_SAMPLE : ST_IDLE;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_SAMPLE: begin
        state_d = ST_EMIT;
        col_d   = '0;
      end
      default: begin
        // Pending key with a busy slot holds the walk on this column.
        if (!pending[cur_idx] || slot_free) begin
          if (flip) begin
            key_valid_d = 1'b1;
            key_code_d  = CODE_W'(KEY_CODE(32'(row_q), 32'(col_q), COLS));
            key_press_d = ~stable[cur_idx];
          end
          if (col_q == CW'(COLS - 1)) begin
            col_d   = '0;
            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
            dwell_d = '0;
            state_d = ST_DRIVE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
    endcase

    row_n_d = (state_d == ST_IDLE) ? '1 : ~(ROWS'(1) << row_d);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      dwell_q     <= '0;
      row_n_q     <= '1;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_press_q <= 1'b0;
      overrun_q   <= 1'b0;
      col_s1_q    <= '1;
      col_s2_q    <= '1;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      row_n_q     <= row_n_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_press_q <= key_press_d;
      overrun_q   <= overrun_d;
      col_s1_q    <= col_n;
      col_s2_q    <= col_s1_q;
    end
  end

  assign row_n            = row_n_q;
  assign overrun          = overrun_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_code  = key_code_q;
  assign key_if.key_press = key_press_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a 5x7 switch-matrix model, SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_matrix_scanner;
  localparam int P = 4 + 1 + 7;  // clocks per row: dwell + sample + emit walk

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [6:0]      col_n;
  logic [4:0]      row_n;
  logic            overrun;
  logic [4:0][6:0] pressed;
  logic [6:0]      ev[$];
  int              tests = 0;
  int              fails = 0;
  int              n;

  keypad_matrix_scanner_if #(.CODE_W(6)) kif ();

  keypad_matrix_scanner #(
    .ROWS(5), .COLS(7), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .CODE_W(6)
  ) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .en       (en),
    .col_n    (col_n),
    .row_n    (row_n),
    .overrun  (overrun),
    .key_if   (kif)
  );

  always #5 clk = ~clk;

  // Pressed switch shorts its column to a row that is driven low.
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++)
        if (pressed[r][c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk)
    if (rst_n && kif.key_valid && kif.key_ready) ev.push_back({kif.key_press, kif.key_code});

  function automatic logic [4:0] rowpat(input int r);
    logic [4:0] one;
    one = 5'd1;
    return ~(one << r);
  endfunction

  function automatic logic [31:0] evw(input logic p, input logic [5:0] c);
    return {25'd0, p, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the given row starts being driven.
  task automatic wait_row_start(input int r);
    int k;
    k = 0;
    while (row_n === rowpat(r) && k < 200) begin @(negedge clk); k++; end
    while (row_n !== rowpat(r) && k < 200) begin @(negedge clk); k++; end
    check("row_wait_in_budget", 32'(k < 200), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; kif.key_ready = 1'b1; pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_row_n", 32'(row_n), 32'h1f);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_code", 32'(kif.key_code), 32'd0);
    check("rst_press", 32'(kif.key_press), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // 1: row sequence and wrap, P clocks per row
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("row_seq", 32'(row_n), 32'(rowpat(i % 5)));
      repeat (P) @(negedge clk);
    end

    // 2: row2/col3 press confirmed on the third scan
    ev.delete();
    wait_row_start(0);
    pressed[2][3] = 1'b1;
    wait_row_start(3);
    check("press_scan1_none", 32'(ev.size()), 32'd0);
    wait_row_start(3);
    check("press_scan2_none", 32'(ev.size()), 32'd0);
    wait_row_start(3);
    check("press_count", 32'(ev.size()), 32'd1);
    check("press_event", 32'(ev[0]), evw(1'b1, 6'd17));

    // 3: release of the same key, then a 2-scan glitch on row0/col0
    ev.delete();
    pressed[2][3] = 1'b0;
    wait_row_start(3);
    wait_row_start(3);
    check("release_scan2_none", 32'(ev.size()), 32'd0);
    wait_row_start(3);
    check("release_count", 32'(ev.size()), 32'd1);
    check("release_event", 32'(ev[0]), evw(1'b0, 6'd17));
    ev.delete();
    wait_row_start(1);
    pressed[0][0] = 1'b1;
    wait_row_start(1);
    wait_row_start(1);
    pressed[0][0] = 1'b0;
    wait_row_start(1);
    wait_row_start(1);
    check("glitch_no_event", 32'(ev.size()), 32'd0);

    // 4: two keys in row1 with the consumer stalled
    kif.key_ready = 1'b0;
    wait_row_start(2);
    pressed[1][0] = 1'b1;
    pressed[1][5] = 1'b1;
    wait_row_start(1);
    wait_row_start(1);
    check("stall_pre_valid", 32'(kif.key_valid), 32'd0);
    wait_row_start(1);
    repeat (15) @(negedge clk);
    check("stall_valid", 32'(kif.key_valid), 32'd1);
    check("stall_code", 32'(kif.key_code), 32'd7);
    check("stall_press", 32'(kif.key_press), 32'd1);
    check("stall_row", 32'(row_n), 32'h1d);
    repeat (5) @(negedge clk);
    check("stall_row_held", 32'(row_n), 32'h1d);
    check("stall_code_held", 32'(kif.key_code), 32'd7);
    check("stall_no_accept", 32'(ev.size()), 32'd0);
    kif.key_ready = 1'b1;
    @(negedge clk);
    check("b2b_valid", 32'(kif.key_valid), 32'd1);
    check("b2b_code", 32'(kif.key_code), 32'd12);
    check("b2b_first_accepted", 32'(ev.size()), 32'd1);
    wait_row_start(2);
    check("b2b_count", 32'(ev.size()), 32'd2);
    check("b2b_ev0", 32'(ev[0]), evw(1'b1, 6'd7));
    check("b2b_ev1", 32'(ev[1]), evw(1'b1, 6'd12));

    // 5: reset with an event waiting; held keys must be re-confirmed
    ev.delete();
    kif.key_ready = 1'b0;
    wait_row_start(4);
    pressed[3][2] = 1'b1;
    wait_row_start(4);
    wait_row_start(4);
    wait_row_start(4);
    check("pend_valid", 32'(kif.key_valid), 32'd1);
    check("pend_code", 32'(kif.key_code), 32'd23);
    rst_n = 1'b0;
    #1;
    check("mid_rst_row_n", 32'(row_n), 32'h1f);
    check("mid_rst_valid", 32'(kif.key_valid), 32'd0);
    check("mid_rst_code", 32'(kif.key_code), 32'd0);
    check("mid_rst_press", 32'(kif.key_press), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; kif.key_ready = 1'b1;
    wait_row_start(4);
    wait_row_start(4);
    check("rearm_no_early", 32'(ev.size()), 32'd0);
    wait_row_start(4);
    check("rearm_count", 32'(ev.size()), 32'd3);
    check("rearm_ev0", 32'(ev[0]), evw(1'b1, 6'd7));
    check("rearm_ev1", 32'(ev[1]), evw(1'b1, 6'd12));
    check("rearm_ev2", 32'(ev[2]), evw(1'b1, 6'd23));

    // 6: en dropped mid-DRIVE with a release event still waiting
    ev.delete();
    kif.key_ready = 1'b0;
    pressed[3][2] = 1'b0;
    wait_row_start(4);
    wait_row_start(4);
    wait_row_start(4);
    check("en_pend_valid", 32'(kif.key_valid), 32'd1);
    check("en_pend_press", 32'(kif.key_press), 32'd0);
    wait_row_start(0);
    en = 1'b0;
    n = 0;
    while (row_n !== 5'h1f && n < 13) begin @(negedge clk); n++; end
    check("en_off_rows_idle", 32'(row_n), 32'h1f);
    check("en_off_latency", 32'(n), 32'd4);
    repeat (20) @(negedge clk);
    check("idle_rows_held", 32'(row_n), 32'h1f);
    check("idle_valid_held", 32'(kif.key_valid), 32'd1);
    check("idle_code_held", 32'(kif.key_code), 32'd23);
    kif.key_ready = 1'b1;
    @(negedge clk);
    check("idle_valid_drop", 32'(kif.key_valid), 32'd0);
    check("idle_accept_count", 32'(ev.size()), 32'd1);
    check("idle_accept_event", 32'(ev[0]), evw(1'b0, 6'd23));
    check("final_overrun", 32'(overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
